spi_cmd_ctrl: RTL and testbench
===============================

SPI_CMD_CTRL -- requirements
Module: spi_cmd_ctrl

Interface
REQ-001 The block SHALL have input clk, 1 bit, the 25 MHz system clock; all logic is clocked on its rising edge.
REQ-002 The block SHALL have input rst, 1 bit, an asynchronous active-low reset.
REQ-003 The block SHALL have input cs, 1 bit, the raw SPI chip select (frame active low, asynchronous to clk).
REQ-004 The block SHALL have input byte_in, 8 bits, the received SPI byte, valid only while byte_valid is high.
REQ-005 The block SHALL have input byte_valid, 1 bit, a single-cycle strobe marking one received byte.
REQ-006 The block SHALL have output wr_req, 1 bit, the register-write request to the RISC-V side register bank.
REQ-007 The block SHALL have output wr_addr, 4 bits, the write address, stable while wr_req is high.
REQ-008 The block SHALL have output wr_data, 8 bits, the write data, stable while wr_req is high.
REQ-009 The block SHALL have input wr_ack, 1 bit, the bank's acceptance of the current write.
REQ-010 The block SHALL have output busy, 1 bit, high whenever the state is not IDLE.
REQ-011 The block SHALL have output err_cmd, 1 bit, a sticky flag for an invalid command.
REQ-012 The block SHALL have output err_ovr, 1 bit, a sticky flag for a byte dropped while a write was pending.
REQ-013 The block SHALL have input err_clr, 1 bit; while it is high, err_cmd and err_ovr clear on the next edge, and clearing takes priority over setting.

Function
REQ-014 The block SHALL synchronise cs through two flip-flops, both reset to 1; cs_s is the second stage.
REQ-015 The state machine SHALL have exactly these states: IDLE, CMD, DATA, WAIT_ACK and DISCARD.
REQ-016 IDLE SHALL go to CMD when cs_s is 0, and SHALL ignore byte_valid in IDLE.
REQ-017 In CMD, on byte_valid, the block SHALL decode byte_in[7:6] as follows: 01 is a single write, 10 is a burst write, and 00 or 11 is invalid.
REQ-018 On a valid command, the block SHALL load the internal address register from byte_in[3:0], latch the mode, and go to DATA.
REQ-019 On an invalid command, the block SHALL set err_cmd and go to DISCARD.
REQ-020 The block SHALL ignore byte_in[5:4].
REQ-021 In DATA, on byte_valid, the block SHALL load wr_data with byte_in and wr_addr with the address register, assert wr_req on the next edge, and go to WAIT_ACK.
REQ-022 The latency from a data-byte strobe to wr_req high SHALL be 1 cycle.
REQ-023 In WAIT_ACK, wr_req SHALL stay high and wr_addr and wr_data SHALL stay stable until wr_ack is sampled high.
REQ-024 On the edge that samples wr_ack high, wr_req SHALL go low.
REQ-025 On that same edge, in burst mode the address register SHALL increment modulo 16 (15 wraps to 0) and the state SHALL go to DATA.
REQ-026 On that same edge, in single mode the state SHALL go to DISCARD.
REQ-027 Back-to-back requests SHALL be separated by at least 1 cycle with wr_req low.
REQ-028 A byte_valid in WAIT_ACK SHALL set err_ovr and the byte SHALL be dropped, including when byte_valid and wr_ack occur in the same cycle.
REQ-029 A byte_valid in DISCARD SHALL be ignored without flagging an error.
REQ-030 When cs_s is 1 in CMD, DATA or DISCARD, the state SHALL go to IDLE on the next edge.
REQ-031 When cs_s is 1 in WAIT_ACK, the pending write SHALL still complete, and the state SHALL then go to IDLE instead of DATA or DISCARD.
REQ-032 When cs_s is 1 in the same cycle as byte_valid in CMD or DATA, frame end SHALL take priority and the byte SHALL be ignored.
REQ-033 wr_ack outside WAIT_ACK SHALL be ignored.

Reset
REQ-034 When rst is 0, the block SHALL immediately enter IDLE with wr_req=0, wr_addr=0, wr_data=0, busy=0, err_cmd=0, err_ovr=0, the address register at 0, and both cs synchroniser stages at 1.
REQ-035 Reset asserted mid-transaction SHALL abort the transaction, dropping wr_req without waiting for wr_ack.

Verification
REQ-036 The bench SHALL check single write: cs low, bytes 0x45 then 0xA5, wr_ack after 3 cycles -> one wr_req with wr_addr=5 and wr_data=0xA5, held 3 cycles, and no error.
REQ-037 The bench SHALL check burst wrap: bytes 0x8E, 0x11, 0x22, 0x33 with immediate ack -> writes (E,0x11), (F,0x22), (0,0x33).
REQ-038 The bench SHALL check an invalid command: byte 0xC3 then 0x55 -> err_cmd=1, no wr_req, and IDLE after cs high.
REQ-039 The bench SHALL check overrun: burst 0x80, 0x01, then a second data byte while wr_ack is held low -> err_ovr=1, exactly one write, and err_clr clears the flag.
REQ-040 The bench SHALL check frame end while pending: cs high during WAIT_ACK, then wr_ack -> the write completes, the state returns to IDLE, and busy=0.
REQ-041 The bench SHALL check reset in WAIT_ACK: rst low -> wr_req=0 immediately and all outputs at their reset values.

Source files
------------

// File: rtl/spi_cmd_ctrl.sv
// spi_cmd_ctrl: turns SPI command/data bytes into register-bank write requests.
// A command byte selects single or burst mode and a start address. Each data
// byte then becomes one write handshake (wr_req/wr_ack). Burst mode advances
// the address modulo 16 after every accepted write.
`timescale 1ns/1ps
module spi_cmd_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       cs,
  input  logic [7:0] byte_in,
  input  logic       byte_valid,
  output logic       wr_req,
  output logic [3:0] wr_addr,
  output logic [7:0] wr_data,
  input  logic       wr_ack,
  output logic       busy,
  output logic       err_cmd,
  output logic       err_ovr,
  input  logic       err_clr
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CMD      = 3'd1,
    DATA     = 3'd2,
    WAIT_ACK = 3'd3,
    DISCARD  = 3'd4
  } state_t;

  state_t     state_r;
  logic       cs_meta_r;
  logic       cs_s;
  logic [3:0] addr_r;
  logic       burst_r;

  // Opcode 01 is a single write and 10 a burst write; 00 and 11 are rejected.
  function automatic logic cmd_valid(input logic [1:0] op);
    return (op == 2'b01) || (op == 2'b10);
  endfunction

  // Two-stage synchroniser for the asynchronous chip select (idle high).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cs_meta_r <= 1'b1;
      cs_s      <= 1'b1;
    end else begin
      cs_meta_r <= cs;
      cs_s      <= cs_meta_r;
    end
  end

  // Frame state machine with registered write handshake, busy and sticky errors.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
      wr_req  <= 1'b0;
      wr_addr <= 4'd0;
      wr_data <= 8'd0;
      busy    <= 1'b0;
      err_cmd <= 1'b0;
      err_ovr <= 1'b0;
      addr_r  <= 4'd0;
      burst_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          // Bytes arriving before the frame is seen are ignored.
          if (!cs_s) begin
            state_r <= CMD;
            busy    <= 1'b1;
          end
        end
        CMD: begin
          // Frame end wins over a byte strobe in the same cycle.
          if (cs_s) begin
            state_r <= IDLE;
            busy    <= 1'b0;
          end else if (byte_valid) begin
            if (cmd_valid(byte_in[7:6])) begin
              addr_r  <= byte_in[3:0];
              burst_r <= (byte_in[7:6] == 2'b10);
              state_r <= DATA;
            end else begin
              err_cmd <= 1'b1;
              state_r <= DISCARD;
            end
          end
        end
        DATA: begin
          if (cs_s) begin
            state_r <= IDLE;
            busy    <= 1'b0;
          end else if (byte_valid) begin
            wr_data <= byte_in;
            wr_addr <= addr_r;
            wr_req  <= 1'b1;
            state_r <= WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          // Any byte arriving while a write is outstanding is lost.
          if (byte_valid) begin
            err_ovr <= 1'b1;
          end
          // A pending write always completes, even after the frame has ended.
          if (wr_ack) begin
            wr_req <= 1'b0;
            if (burst_r) begin
              addr_r <= addr_r + 4'd1;
            end
            if (cs_s) begin
              state_r <= IDLE;
              busy    <= 1'b0;
            end else if (burst_r) begin
              state_r <= DATA;
            end else begin
              state_r <= DISCARD;
            end
          end
        end
        DISCARD: begin
          if (cs_s) begin
            state_r <= IDLE;
            busy    <= 1'b0;
          end
        end
        default: begin
          state_r <= IDLE;
          wr_req  <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
      // Clearing overrides any error raised in the same cycle.
      if (err_clr) begin
        err_cmd <= 1'b0;
        err_ovr <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spi_cmd_ctrl.sv
// Self-checking bench for spi_cmd_ctrl: a cycle-level behavioural model of the
// frame protocol is compared against the DUT on every falling clock edge, and
// directed scenarios pin the observed writes and flags to hand-computed values.
`timescale 1ns/1ps
module tb_spi_cmd_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cs = 1'b1;
  logic [7:0] byte_in = 8'h00;
  logic       byte_valid = 1'b0;
  logic       wr_ack = 1'b0;
  logic       err_clr = 1'b0;
  logic       wr_req;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic       busy;
  logic       err_cmd;
  logic       err_ovr;

  int vectors = 0;
  int miscompares = 0;

  logic [11:0] dut_log[$];
  int          req_cycles = 0;
  int          base;

  spi_cmd_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .cs        (cs),
    .byte_in   (byte_in),
    .byte_valid(byte_valid),
    .wr_req    (wr_req),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_ack    (wr_ack),
    .busy      (busy),
    .err_cmd   (err_cmd),
    .err_ovr   (err_ovr),
    .err_clr   (err_clr)
  );

  always #20 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  localparam int FRAME_OFF  = 0;
  localparam int AWAIT_CMD  = 1;
  localparam int AWAIT_DATA = 2;
  localparam int PENDING    = 3;
  localparam int SKIP       = 4;

  int         m_phase = FRAME_OFF;
  logic [1:0] m_cs_hist = 2'b11;   // [0] first stage, [1] value the FSM sees
  logic       m_req = 1'b0;
  logic [3:0] m_waddr = 4'd0;
  logic [7:0] m_wdata = 8'd0;
  int         m_next_addr = 0;
  bit         m_burst = 1'b0;
  logic       m_ecmd = 1'b0;
  logic       m_eovr = 1'b0;

  initial forever begin
    @(posedge clk or negedge rst);
    if (!rst) begin
      m_phase = FRAME_OFF; m_cs_hist = 2'b11; m_req = 1'b0;
      m_waddr = 4'd0; m_wdata = 8'd0; m_next_addr = 0;
      m_burst = 1'b0; m_ecmd = 1'b0; m_eovr = 1'b0;
    end else begin
      automatic bit frame_done = m_cs_hist[1];
      automatic int op = int'(byte_in) / 64;
      if (m_phase == FRAME_OFF) begin
        if (!frame_done) m_phase = AWAIT_CMD;
      end else if (m_phase == PENDING) begin
        if (byte_valid) m_eovr = 1'b1;
        if (wr_ack) begin
          m_req = 1'b0;
          if (m_burst) m_next_addr = (m_next_addr + 1) % 16;
          m_phase = frame_done ? FRAME_OFF : (m_burst ? AWAIT_DATA : SKIP);
        end
      end else if (frame_done) begin
        m_phase = FRAME_OFF;
      end else if (byte_valid && m_phase == AWAIT_CMD) begin
        if (op == 1 || op == 2) begin
          m_next_addr = int'(byte_in) % 16;
          m_burst = (op == 2);
          m_phase = AWAIT_DATA;
        end else begin
          m_ecmd = 1'b1;
          m_phase = SKIP;
        end
      end else if (byte_valid && m_phase == AWAIT_DATA) begin
        m_req = 1'b1;
        m_waddr = 4'(m_next_addr);
        m_wdata = byte_in;
        m_phase = PENDING;
      end
      if (err_clr) begin
        m_ecmd = 1'b0;
        m_eovr = 1'b0;
      end
      m_cs_hist = {m_cs_hist[0], cs};
    end
  end

  // Per-cycle comparison against the model, plus a log of completed writes.
  initial forever begin
    @(negedge clk);
    check("wr_req",  wr_req,  m_req);
    check("wr_addr", wr_addr, m_waddr);
    check("wr_data", wr_data, m_wdata);
    check("busy",    busy,    (m_phase != FRAME_OFF));
    check("err_cmd", err_cmd, m_ecmd);
    check("err_ovr", err_ovr, m_eovr);
    if (wr_req === 1'b1) req_cycles++;
    if (wr_req === 1'b1 && wr_ack === 1'b1) dut_log.push_back({wr_addr, wr_data});
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic open_frame();
    cs = 1'b0;
    repeat (3) tick();
  endtask

  task automatic close_frame();
    cs = 1'b1;
    repeat (4) tick();
  endtask

  task automatic send(input logic [7:0] b);
    byte_in = b;
    byte_valid = 1'b1;
    tick();
    byte_valid = 1'b0;
  endtask

  task automatic wait_req();
    for (int i = 0; i < 8 && wr_req !== 1'b1; i++) tick();
    check("req_seen", wr_req, 1'b1);
  endtask

  task automatic ack_now();
    wait_req();
    wr_ack = 1'b1;
    tick();
    wr_ack = 1'b0;
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- directed scenarios ----------------
  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_wr_req", wr_req, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_addr_data", {wr_addr, wr_data}, 12'h000);
    check("rst_errs", {err_cmd, err_ovr}, 2'b00);
    rst = 1'b1;
    repeat (2) tick();

    // Single write held for three cycles before acknowledge.
    base = dut_log.size();
    req_cycles = 0;
    open_frame();
    send(8'h45);
    send(8'hA5);
    wait_req();
    tick(); tick();
    wr_ack = 1'b1;
    tick();
    wr_ack = 1'b0;
    close_frame();
    check("single_count", dut_log.size() - base, 1);
    if (dut_log.size() > base) check("single_write", dut_log[base], 12'h5A5);
    check("single_hold", req_cycles, 3);
    check("single_errs", {err_cmd, err_ovr}, 2'b00);
    check("single_idle", busy, 1'b0);

    // Burst with address wrap from 0xF to 0x0.
    base = dut_log.size();
    open_frame();
    send(8'h8E);
    send(8'h11); ack_now();
    send(8'h22); ack_now();
    send(8'h33); ack_now();
    close_frame();
    check("burst_count", dut_log.size() - base, 3);
    if (dut_log.size() >= base + 3) begin
      check("burst_w0", dut_log[base],     12'hE11);
      check("burst_w1", dut_log[base + 1], 12'hF22);
      check("burst_w2", dut_log[base + 2], 12'h033);
    end

    // Invalid command: later bytes discarded, error sticky until cleared.
    base = dut_log.size();
    open_frame();
    send(8'hC3);
    send(8'h55);
    tick();
    check("badcmd_flag", err_cmd, 1'b1);
    close_frame();
    check("badcmd_nowrite", dut_log.size() - base, 0);
    check("badcmd_idle", busy, 1'b0);
    check("badcmd_sticky", err_cmd, 1'b1);
    pulse_clr();
    check("badcmd_clr", err_cmd, 1'b0);

    // Overrun while the write is pending, including byte coincident with ack.
    base = dut_log.size();
    open_frame();
    send(8'h80);
    send(8'h01);
    tick();
    send(8'h02);
    check("ovr_flag", err_ovr, 1'b1);
    check("ovr_still_req", wr_req, 1'b1);
    pulse_clr();
    check("ovr_clr", err_ovr, 1'b0);
    wr_ack = 1'b1;
    byte_in = 8'h03;
    byte_valid = 1'b1;
    tick();
    wr_ack = 1'b0;
    byte_valid = 1'b0;
    check("ovr_same_cycle", err_ovr, 1'b1);
    close_frame();
    check("ovr_count", dut_log.size() - base, 1);
    if (dut_log.size() > base) check("ovr_write", dut_log[base], 12'h001);
    pulse_clr();
    check("ovr_clr2", err_ovr, 1'b0);

    // Frame ends while a write is pending: write completes, then idle.
    base = dut_log.size();
    open_frame();
    send(8'h45);
    send(8'h77);
    cs = 1'b1;
    repeat (3) tick();
    check("pend_req", wr_req, 1'b1);
    check("pend_busy", busy, 1'b1);
    wr_ack = 1'b1;
    tick();
    wr_ack = 1'b0;
    check("pend_req_low", wr_req, 1'b0);
    check("pend_idle", busy, 1'b0);
    tick();
    check("pend_count", dut_log.size() - base, 1);
    if (dut_log.size() > base) check("pend_write", dut_log[base], 12'h577);

    // Reset while waiting for acknowledge.
    open_frame();
    send(8'h41);
    send(8'h99);
    send(8'h12);
    check("rstw_ovr", err_ovr, 1'b1);
    check("rstw_req", wr_req, 1'b1);
    #5;
    rst = 1'b0;
    #1;
    check("rstw_req_low", wr_req, 1'b0);
    check("rstw_busy", busy, 1'b0);
    check("rstw_addr_data", {wr_addr, wr_data}, 12'h000);
    check("rstw_errs", {err_cmd, err_ovr}, 2'b00);
    cs = 1'b1;
    repeat (2) tick();
    rst = 1'b1;
    repeat (3) tick();
    check("rstw_after", busy, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
